// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment driver.
// Glyphs are active-low with segment a on bit 6 through segment g on bit 0.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;

  localparam int unsigned MAX_DIGITS = 16;

  typedef enum logic {
    PH_GUARD,
    PH_LIT
  } slot_phase_e;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

  // Number of zero nibbles counted down from the top digit, stopping at the
  // first non-zero one; digit 0 is never counted so it always stays visible.
  function automatic int unsigned lz_width(input logic [4*MAX_DIGITS-1:0] val,
                                           input int unsigned             digits);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int unsigned k = MAX_DIGITS - 1; k > 0; k--) begin
      if (k < digits) begin
        if (run && (val[4*k +: 4] == 4'h0)) begin
          n = n + 1;
        end else begin
          run = 1'b0;
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex_glyph(nib_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver for common-anode 7-segment banks with
// frame-synchronous updates, leading-zero blanking and an anode guard interval.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned GUARD    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] value_i,
  input  logic [DIGITS-1:0]   dp_i,
  input  logic                blank_lz_i,
  output logic [6:0]          seg_o,
  output logic                dp_o,
  output logic [DIGITS-1:0]   an_o,
  output logic                frame_o
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PCNT_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PCNT_GUARD = PW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          wrap_q, wrap_d;
  logic          tick, wrap_tick;

  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_lz_q, pend_lz_d;
  logic                pend_v_q, pend_v_d;
  logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                disp_lz_q, disp_lz_d;

  logic [4*MAX_DIGITS-1:0] val_ext;
  int unsigned             lz_n;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [6:0]              cur_glyph;
  slot_phase_e             phase;

  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_q, frame_d;

  // Prescaler and digit index; both freeze while the scan is disabled.
  always_comb begin
    tick      = en_i && (pcnt_q == PCNT_LAST);
    wrap_tick = tick && (idx_q == IDX_LAST);
    pcnt_d    = pcnt_q;
    idx_d     = idx_q;
    wrap_d    = wrap_q;
    if (en_i) begin
      wrap_d = wrap_tick;
      if (tick) begin
        pcnt_d = '0;
        idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
    end
  end

  // A load on the wrap-tick bypasses pending so it lands in the very next frame.
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_lz_d  = pend_lz_q;
    pend_v_d   = pend_v_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    disp_lz_d  = disp_lz_q;
    if (load_i) begin
      pend_val_d = value_i;
      pend_dp_d  = dp_i;
      pend_lz_d  = blank_lz_i;
      pend_v_d   = 1'b1;
    end
    if (wrap_tick) begin
      pend_v_d = 1'b0;
      if (load_i) begin
        disp_val_d = value_i;
        disp_dp_d  = dp_i;
        disp_lz_d  = blank_lz_i;
      end else if (pend_v_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
        disp_lz_d  = pend_lz_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_lz_q  <= 1'b0;
      pend_v_q   <= 1'b0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      disp_lz_q  <= 1'b0;
    end else begin
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_lz_q  <= pend_lz_d;
      pend_v_q   <= pend_v_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      disp_lz_q  <= disp_lz_d;
    end
  end

  // Digit select, leading-zero mask and slot phase for the current scan slot.
  always_comb begin
    val_ext                 = '0;
    val_ext[4*DIGITS-1:0]   = disp_val_q;
    lz_n                    = lz_width(val_ext, DIGITS);
    cur_nib                 = '0;
    cur_dp                  = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib = disp_val_q[4*i +: 4];
        cur_dp  = disp_dp_q[i];
      end
    end
    cur_blank = disp_lz_q && (32'(idx_q) >= (DIGITS - lz_n));
    phase     = (pcnt_q < PCNT_GUARD) ? PH_GUARD : PH_LIT;
  end

  hex_to_seg7 u_glyph (
    .nib_i (cur_nib),
    .seg_o (cur_glyph)
  );

  always_comb begin
    an_d    = '1;
    seg_d   = SEG_OFF;
    dp_d    = 1'b1;
    frame_d = 1'b0;
    if (en_i) begin
      frame_d = wrap_q;
      seg_d   = cur_blank ? SEG_OFF : cur_glyph;
      dp_d    = ~cur_dp;
      if (phase == PH_LIT) begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          an_d[i] = (idx_q != IW'(i));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule
